// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, word-addressed data memory,
// read-modify-write for SB/SH, sign/zero extension of load data.
module load_store_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rwenable,
    output logic        mem_rwset,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, RESP} state_t;

    state_t            state, state_next;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        off_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              req_err;

    function automatic logic access_err(input logic st, input logic [2:0] f3,
                                        input logic [31:0] addr);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        bad |= st && f3[2];
        bad |= (f3[1:0] == 2'b01) && addr[0];
        bad |= (f3[1:0] == 2'b10) && (addr[1:0] != 2'b00);
        bad |= ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
        return bad;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Store data is kept in word_q until the old word arrives, then replaced by the merge.
    function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] m;
        m = w;
        case (f3[1:0])
            2'b00:   m[{off, 3'b000} +: 8] = d[7:0];
            2'b01:   m[{off[1], 4'b0000} +: 16] = d[15:0];
            default: m = d;
        endcase
        return m;
    endfunction

    assign req_err = access_err(req_store, req_funct3, req_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        funct3_q <= req_funct3;
                        idx_q    <= req_addr[IDX_W+1:2];
                        off_q    <= req_addr[1:0];
                        word_q   <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                    end
                end
                RWAIT: begin
                    if (store_q) begin
                        word_q <= merge(funct3_q, off_q, mem_rdata, word_q);
                    end else begin
                        rdata_q <= extract(funct3_q, off_q, mem_rdata);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_rwenable = 1'b0;
        mem_rwset    = 1'b0;
        mem_funct3   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (req_store && (req_funct3 == 3'b010)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ, RWAIT: begin
                mem_rwenable = 1'b1;
                mem_funct3   = 3'b010;
                mem_addr     = {{(32-IDX_W){1'b0}}, idx_q};
                if (state == READ) begin
                    state_next = RWAIT;
                end else begin
                    state_next = store_q ? WRITE : RESP;
                end
            end
            WRITE: begin
                mem_rwenable = 1'b1;
                mem_rwset    = 1'b1;
                mem_funct3   = 3'b010;
                mem_addr     = {{(32-IDX_W){1'b0}}, idx_q};
                mem_wdata    = word_q;
                state_next   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, expected responses queued
// per request and compared when the response appears.
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;
    localparam int IDX_W     = 10;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rwenable;
    logic        mem_rwset;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rwenable(mem_rwenable),
        .mem_rwset(mem_rwset), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Word memory with one-cycle read latency; preset port lets the bench seed words.
    logic [31:0]      mem [MEM_WORDS];
    logic             preset_en = 1'b0;
    logic [IDX_W-1:0] preset_idx = '0;
    logic [31:0]      preset_val = '0;

    always @(posedge clk) begin
        if (preset_en) begin
            mem[preset_idx] <= preset_val;
        end else if (mem_rwenable) begin
            if (mem_rwset) mem[mem_addr[IDX_W-1:0]] <= mem_wdata;
            else           mem_rdata <= mem[mem_addr[IDX_W-1:0]];
        end
    end

    int          wr_cnt = 0;
    int          en_cnt = 0;
    int          f3_bad = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (mem_rwenable) begin
            en_cnt++;
            if (mem_funct3 !== 3'b010) f3_bad++;
            if (mem_rwset) begin
                wr_cnt++;
                last_waddr = mem_addr;
                last_wdata = mem_wdata;
            end
        end else if (mem_funct3 !== 3'b000) begin
            f3_bad++;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        int          nen;
        logic [31:0] wword;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_lat;
    int          obs_nwr;
    int          obs_nen;

    task automatic preset(input int idx, input logic [31:0] v);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_idx = IDX_W'(idx);
        preset_val = v;
        @(posedge clk);
        #1 preset_en = 1'b0;
    endtask

    task automatic run_txn(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        int wr0;
        int en0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        wr0 = wr_cnt;
        en0 = en_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        obs_lat = 0;
        while (obs_lat < 20) begin
            @(negedge clk);
            obs_lat++;
            if (resp_valid) break;
        end
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        obs_nwr = wr_cnt - wr0;
        obs_nen = en_cnt - en0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
            fails++; $display("FAIL reset_handshake: got %b want 100", {req_ready, resp_valid, resp_err});
        end
        tests++; if (resp_rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got %h want 00000000", resp_rdata);
        end
        tests++; if ({mem_rwenable, mem_rwset, mem_funct3} !== 5'b0) begin
            fails++; $display("FAIL reset_mem_ctrl: got %b want 00000", {mem_rwenable, mem_rwset, mem_funct3});
        end
        tests++; if ({mem_addr, mem_wdata} !== 64'h0) begin
            fails++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_sw_lw;
        sb.push_back('{32'h0, 1'b0, 2, 1, 1, 32'hDEADBEEF});
        run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        e = sb.pop_front();
        tests++; if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin
            fails++; $display("FAIL sw_resp: got err=%b rdata=%h want err=%b rdata=%h", obs_err, obs_rdata, e.err, e.rdata);
        end
        tests++; if (obs_lat != e.lat || obs_nwr != e.nwr || obs_nen != e.nen) begin
            fails++; $display("FAIL sw_timing: got lat=%0d wr=%0d en=%0d want %0d/%0d/%0d", obs_lat, obs_nwr, obs_nen, e.lat, e.nwr, e.nen);
        end
        tests++; if (last_waddr !== 32'd4 || last_wdata !== e.wword) begin
            fails++; $display("FAIL sw_write: got addr=%h data=%h want 4/%h", last_waddr, last_wdata, e.wword);
        end
        sb.push_back('{32'hDEADBEEF, 1'b0, 3, 0, 2, 32'h0});
        run_txn(1'b0, 3'b010, 32'h10, 32'h0);
        e = sb.pop_front();
        tests++; if ({obs_err, obs_rdata} !== {e.err, e.rdata}) begin
            fails++; $display("FAIL lw_resp: got err=%b rdata=%h want err=%b rdata=%h", obs_err, obs_rdata, e.err, e.rdata);
        end
        tests++; if (obs_lat != e.lat || obs_nwr != e.nwr || obs_nen != e.nen) begin
            fails++; $display("FAIL lw_timing: got lat=%0d wr=%0d en=%0d want %0d/%0d/%0d", obs_lat, obs_nwr, obs_nen, e.lat, e.nwr, e.nen);
        end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] xs  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        preset(4, 32'h80FF_7F01);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{xs[i], 1'b0, 3, 0, 2, 32'h0});
            run_txn(1'b0, f3s[i], as[i], 32'h0);
            e = sb.pop_front();
            tests++; if ({obs_err, obs_rdata} !== {e.err, e.rdata} || obs_lat != e.lat || obs_nwr != e.nwr) begin
                fails++; $display("FAIL load_ext[%0d]: got err=%b rdata=%h lat=%0d wr=%0d want err=%b rdata=%h lat=%0d wr=%0d",
                                  i, obs_err, obs_rdata, obs_lat, obs_nwr, e.err, e.rdata, e.lat, e.nwr);
            end
        end
    endtask

    task automatic test_rmw;
        logic [2:0]  f3s [2] = '{3'b000, 3'b001};
        logic [31:0] as  [2] = '{32'h12, 32'h10};
        logic [31:0] wds [2] = '{32'h1234_56AB, 32'h9876_CAFE};
        logic [31:0] xs  [2] = '{32'h11AB_3344, 32'h11AB_CAFE};
        preset(4, 32'h1122_3344);
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{32'h0, 1'b0, 4, 1, 3, xs[i]});
            run_txn(1'b1, f3s[i], as[i], wds[i]);
            e = sb.pop_front();
            tests++; if (obs_lat != e.lat || obs_nwr != e.nwr || obs_nen != e.nen || {obs_err, obs_rdata} !== {e.err, e.rdata}) begin
                fails++; $display("FAIL rmw_timing[%0d]: got lat=%0d wr=%0d en=%0d err=%b want %0d/%0d/%0d/%b",
                                  i, obs_lat, obs_nwr, obs_nen, obs_err, e.lat, e.nwr, e.nen, e.err);
            end
            tests++; if (last_waddr !== 32'd4 || last_wdata !== e.wword || mem[4] !== e.wword) begin
                fails++; $display("FAIL rmw_word[%0d]: got addr=%h data=%h mem=%h want 4/%h", i, last_waddr, last_wdata, mem[4], e.wword);
            end
        end
    endtask

    task automatic test_errors;
        logic        sts [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b001};
        logic [31:0] as  [6] = '{32'h12, 32'h11, 32'h10, 32'h1000, 32'h10, 32'h13};
        for (int i = 0; i < 6; i++) begin
            sb.push_back('{32'h0, 1'b1, 1, 0, 0, 32'h0});
            run_txn(sts[i], f3s[i], as[i], 32'hFFFF_FFFF);
            e = sb.pop_front();
            tests++; if ({obs_err, obs_rdata} !== {e.err, e.rdata} || obs_lat != e.lat || obs_nen != e.nen) begin
                fails++; $display("FAIL error[%0d]: got err=%b rdata=%h lat=%0d en=%0d want err=%b rdata=%h lat=%0d en=%0d",
                                  i, obs_err, obs_rdata, obs_lat, obs_nen, e.err, e.rdata, e.lat, e.nen);
            end
        end
        tests++; if (mem[4] !== 32'h11AB_CAFE) begin
            fails++; $display("FAIL error_mem_untouched: got %h want 11abcafe", mem[4]);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        int bad;
        preset(5, 32'hA5A5_5A5A);
        sb.push_back('{32'hA5A5_5A5A, 1'b0, 3, 0, 2, 32'h0});
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        e = sb.pop_front();
        tests++; if (lat != e.lat || resp_rdata !== e.rdata) begin
            fails++; $display("FAIL bp_first: got lat=%0d rdata=%h want %0d/%h", lat, resp_rdata, e.lat, e.rdata);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin
            fails++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        tests++; if ({req_ready, resp_valid} !== 2'b10) begin
            fails++; $display("FAIL bp_release: got ready/valid=%b want 10", {req_ready, resp_valid});
        end
    endtask

    task automatic test_reset_mid;
        int wr0;
        int bad;
        preset(8, 32'h5566_7788);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h21;
        req_wdata  = 32'h0000_00AA;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++; if ({mem_rwenable, mem_rwset} !== 2'b11) begin
            fails++; $display("FAIL rst_mid_in_write: got en/set=%b want 11", {mem_rwenable, mem_rwset});
        end
        rst = 1'b1;
        #1;
        tests++; if (mem_rwenable !== 1'b0) begin
            fails++; $display("FAIL rst_mid_async: got mem_rwenable=%b want 0", mem_rwenable);
        end
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) bad++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        tests++; if (bad != 0 || wr_cnt != wr0) begin
            fails++; $display("FAIL rst_mid_abandon: got bad=%0d writes=%0d want 0/0", bad, wr_cnt - wr0);
        end
        sb.push_back('{32'h5566_7788, 1'b0, 3, 0, 2, 32'h0});
        run_txn(1'b0, 3'b010, 32'h20, 32'h0);
        e = sb.pop_front();
        tests++; if ({obs_err, obs_rdata} !== {e.err, e.rdata} || obs_lat != e.lat) begin
            fails++; $display("FAIL rst_mid_readback: got err=%b rdata=%h lat=%0d want %b/%h/%0d", obs_err, obs_rdata, obs_lat, e.err, e.rdata, e.lat);
        end
    endtask

    task automatic test_back_to_back;
        int          idx;
        logic [31:0] v;
        logic [1:0]  o;
        logic [31:0] bx;
        for (int i = 0; i < 6; i++) begin
            idx = $urandom_range(0, MEM_WORDS - 1);
            v   = $urandom;
            o   = 2'($urandom_range(0, 3));
            bx  = (v >> (8 * o)) & 32'hFF;
            sb.push_back('{32'h0, 1'b0, 2, 1, 1, v});
            run_txn(1'b1, 3'b010, 32'(idx) << 2, v);
            e = sb.pop_front();
            tests++; if (obs_lat != e.lat || obs_nwr != e.nwr || last_waddr !== 32'(idx) || last_wdata !== e.wword) begin
                fails++; $display("FAIL b2b_sw[%0d]: got lat=%0d wr=%0d addr=%h data=%h want %0d/%0d/%h/%h",
                                  i, obs_lat, obs_nwr, last_waddr, last_wdata, e.lat, e.nwr, 32'(idx), e.wword);
            end
            sb.push_back('{bx, 1'b0, 3, 0, 2, 32'h0});
            run_txn(1'b0, 3'b100, (32'(idx) << 2) | 32'(o), 32'h0);
            e = sb.pop_front();
            tests++; if ({obs_err, obs_rdata} !== {e.err, e.rdata} || obs_lat != e.lat) begin
                fails++; $display("FAIL b2b_lbu[%0d]: got err=%b rdata=%h lat=%0d want %b/%h/%0d", i, obs_err, obs_rdata, obs_lat, e.err, e.rdata, e.lat);
            end
        end
        tests++; if (f3_bad != 0) begin
            fails++; $display("FAIL mem_funct3: got %0d bad cycles want 0", f3_bad);
        end
        tests++; if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_load_ext();
        test_rmw();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule
